// File: rtl/audio_pkg.sv
// Shared audio record-path definitions: sample width, capture states, PDM clock divider default.
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int PDM_CLK_DIV = 40;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} capture_state_t;
endpackage

// File: rtl/pdm_clk_divider.sv
// PDM microphone clock generator. Produces the registered mic clock and a
// one-cycle sampling strobe in the last cycle of the clock's high phase.
module pdm_clk_divider #(
  parameter int CLK_DIV = 40
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic run,     // capture wanted next cycle (enable level)
  input  logic active,  // capture FSM currently out of IDLE
  output logic pdm_clk,
  output logic strobe
);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;

  // Counter advances only while active and still enabled, so it reads 0 in
  // every IDLE cycle, including the first one after enable drops.
  always_comb begin
    div_next = '0;
    if (run && active)
      div_next = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
  end

  // The clock is registered from the next count so it rises the cycle after
  // enable is first seen and drops the cycle after enable is seen low.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pdm_clk <= run && (div_next < DW'(HALF));
    end
  end

  assign strobe = active && (div_cnt == DW'(HALF - 1));
endmodule

// File: rtl/pdm_capture.sv
// PDM microphone capture: clocks the mic, synchronizes the 1-bit stream and
// boxcar-decimates it into unsigned 16-bit PCM samples with a done pulse.
module pdm_capture
  import audio_pkg::*;
#(
  parameter int CLK_DIV        = PDM_CLK_DIV,
  parameter int WINDOW         = 64,
  parameter int WARMUP_WINDOWS = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  output logic                done_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                busy_o,
  output logic                pdm_clk_o,
  input  logic                pdm_data_i,
  output logic                pdm_lrsel_o
);
  localparam int OW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(WINDOW);
  localparam int SH = SAMPLE_W - $clog2(WINDOW);
  localparam int WW = (WARMUP_WINDOWS > 0) ? $clog2(WARMUP_WINDOWS + 1) : 1;

  capture_state_t state;
  logic [1:0]     sync;
  logic           strobe;
  logic [BW-1:0]  bit_cnt;
  logic [OW-1:0]  ones_cnt;
  logic [OW-1:0]  ones_sum;
  logic [WW-1:0]  warm_cnt;
  logic           win_end;

  // Full count saturates: WINDOW << SH would overflow the sample width.
  function automatic logic [SAMPLE_W-1:0] scale(input logic [OW-1:0] n);
    if (n == OW'(WINDOW)) return '1;
    return SAMPLE_W'(n) << SH;
  endfunction

  // Two-flop synchronizer for the asynchronous mic data.
  always_ff @(posedge clock_i) begin
    if (!reset_i) sync <= '0;
    else          sync <= {sync[0], pdm_data_i};
  end

  pdm_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .run     (enable_i),
    .active  (state != IDLE),
    .pdm_clk (pdm_clk_o),
    .strobe  (strobe)
  );

  assign ones_sum    = ones_cnt + OW'(sync[1]);
  assign win_end     = strobe && (bit_cnt == BW'(WINDOW - 1));
  assign pdm_lrsel_o = 1'b0;

  // Capture FSM with window counters and registered sample/done/busy.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      warm_cnt <= '0;
      done_o   <= 1'b0;
      sample_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          ones_cnt <= '0;
          warm_cnt <= '0;
          if (enable_i) begin
            state  <= (WARMUP_WINDOWS == 0) ? RUN : WARMUP;
            busy_o <= 1'b1;
          end
        end
        WARMUP, RUN: begin
          if (strobe) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (win_end) begin
              // Every window starts from an empty count, so warm-up data
              // never leaks into the first real sample.
              ones_cnt <= '0;
              if (state == RUN) begin
                sample_o <= scale(ones_sum);
                done_o   <= 1'b1;
              end else begin
                warm_cnt <= warm_cnt + 1'b1;
                if (warm_cnt == WW'(WARMUP_WINDOWS - 1)) state <= RUN;
              end
            end else begin
              ones_cnt <= ones_sum;
            end
          end
          // Disable wins over the window bookkeeping but a sample finished
          // in this same cycle is still delivered.
          if (!enable_i) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            warm_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
